// File: rtl/mlu_seq.sv
// Operation sequencer feeding a combinational 32-bit MLU: runs one pass (narrow) or two chained passes (wide).
// Optional build macro MLU_SEQ_BACK_TO_BACK_EN lets DONE retire a result and accept the next request on the same edge.
module mlu_seq #(
  parameter int unsigned HI_PASS_EN = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [2:0]  REQ_OP,
  input  logic [63:0] REQ_A,
  input  logic [63:0] REQ_B,
  input  logic        REQ_WIDE,
  input  logic        REQ_USE_CARRY,
  input  logic        REQ_CARRY,
  output logic [31:0] MLU_A,
  output logic [31:0] MLU_B,
  output logic [2:0]  MLU_OP,
  output logic        MLU_C_IN,
  input  logic [31:0] MLU_OUT,
  input  logic        MLU_Z,
  input  logic        MLU_C,
  input  logic        MLU_N,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic [63:0] RES_OUT,
  output logic        RES_Z,
  output logic        RES_C,
  output logic        RES_N,
  output logic [1:0]  DBG_STATE
);

  // Handshakes: a transfer happens on a rising CLK edge where valid and ready are both 1;
  // valid never depends on ready, and RES_* stays stable while RES_VALID=1 and RES_READY=0.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Opcode values mirror the common::MLU_* encoding used by the MLU.
  localparam logic [2:0] MLU_NOP0 = 3'd0;
  localparam logic [2:0] MLU_ADD  = 3'd1;
  localparam logic [2:0] MLU_SUB  = 3'd2;

  logic [1:0]  state;
  logic [2:0]  op_q;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic        wide_q;
  logic        use_carry_q;
  logic        carry_in_q;
  logic        carry_q;
  logic        z_lo_q;
  logic [31:0] lo_q;
  logic [63:0] res_out_q;
  logic        res_z_q;
  logic        res_c_q;
  logic        res_n_q;
  logic        is_arith;
  logic        accept;
  logic        req_wide_eff;
  logic        cin_lo;

  assign is_arith     = (op_q == MLU_ADD) || (op_q == MLU_SUB);
  assign req_wide_eff = (HI_PASS_EN != 0) && REQ_WIDE;
  assign accept       = REQ_VALID && REQ_READY;

  always_comb begin
    REQ_READY = 1'b0;
    case (state)
      S_IDLE: REQ_READY = 1'b1;
`ifdef MLU_SEQ_BACK_TO_BACK_EN
      S_DONE: REQ_READY = RES_READY;
`else
      S_DONE: REQ_READY = 1'b0;
`endif
      default: REQ_READY = 1'b0;
    endcase
  end

  // SUB relies on the MLU computing A + ~B + C_IN, so a plain subtract needs C_IN=1.
  always_comb begin
    cin_lo = 1'b0;
    case (op_q)
      MLU_ADD: cin_lo = use_carry_q ? carry_in_q : 1'b0;
      MLU_SUB: cin_lo = use_carry_q ? carry_in_q : 1'b1;
      default: cin_lo = 1'b0;
    endcase
  end

  always_comb begin
    MLU_A    = 32'd0;
    MLU_B    = 32'd0;
    MLU_OP   = MLU_NOP0;
    MLU_C_IN = 1'b0;
    case (state)
      S_LO: begin
        MLU_A    = a_q[31:0];
        MLU_B    = b_q[31:0];
        MLU_OP   = op_q;
        MLU_C_IN = cin_lo;
      end
      S_HI: begin
        MLU_A    = a_q[63:32];
        MLU_B    = b_q[63:32];
        MLU_OP   = op_q;
        MLU_C_IN = is_arith & carry_q;
      end
      default: begin
        MLU_A    = 32'd0;
        MLU_B    = 32'd0;
        MLU_OP   = MLU_NOP0;
        MLU_C_IN = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q        <= MLU_NOP0;
      a_q         <= 64'd0;
      b_q         <= 64'd0;
      wide_q      <= 1'b0;
      use_carry_q <= 1'b0;
      carry_in_q  <= 1'b0;
    end else if (accept) begin
      op_q        <= REQ_OP;
      a_q         <= REQ_A;
      b_q         <= REQ_B;
      wide_q      <= req_wide_eff;
      use_carry_q <= REQ_USE_CARRY;
      carry_in_q  <= REQ_CARRY;
    end
  end

  // The low word is staged in lo_q so the visible result only changes when RES_VALID rises.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      carry_q   <= 1'b0;
      z_lo_q    <= 1'b0;
      lo_q      <= 32'd0;
      res_out_q <= 64'd0;
      res_z_q   <= 1'b0;
      res_c_q   <= 1'b0;
      res_n_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) state <= S_LO;
        end
        S_LO: begin
          lo_q    <= MLU_OUT;
          z_lo_q  <= MLU_Z;
          carry_q <= MLU_C;
          if (wide_q) begin
            state <= S_HI;
          end else begin
            res_out_q <= {32'd0, MLU_OUT};
            res_z_q   <= MLU_Z;
            res_c_q   <= is_arith & MLU_C;
            res_n_q   <= MLU_N;
            state     <= S_DONE;
          end
        end
        S_HI: begin
          res_out_q <= {MLU_OUT, lo_q};
          res_z_q   <= z_lo_q & MLU_Z;
          res_c_q   <= is_arith & MLU_C;
          res_n_q   <= MLU_N;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (RES_READY) state <= accept ? S_LO : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign RES_VALID = (state == S_DONE);
  assign RES_OUT   = res_out_q;
  assign RES_Z     = res_z_q;
  assign RES_C     = res_c_q;
  assign RES_N     = res_n_q;
  assign DBG_STATE = state;

endmodule

// File: tb/tb_mlu_seq.sv
// Self-checking bench for mlu_seq: a behavioural MLU drives the DUT, results are compared against a 64-bit arithmetic model.
module tb_mlu_seq;

  localparam logic [2:0] OP_NOP0 = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;

  logic        CLK;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [2:0]  REQ_OP;
  logic [63:0] REQ_A;
  logic [63:0] REQ_B;
  logic        REQ_WIDE;
  logic        REQ_USE_CARRY;
  logic        REQ_CARRY;
  logic [31:0] MLU_A;
  logic [31:0] MLU_B;
  logic [2:0]  MLU_OP;
  logic        MLU_C_IN;
  logic [31:0] MLU_OUT;
  logic        MLU_Z;
  logic        MLU_C;
  logic        MLU_N;
  logic        RES_VALID;
  logic        RES_READY;
  logic [63:0] RES_OUT;
  logic        RES_Z;
  logic        RES_C;
  logic        RES_N;
  logic [1:0]  DBG_STATE;

  int n_checks = 0;
  int n_errors = 0;

  mlu_seq dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_WIDE(REQ_WIDE),
    .REQ_USE_CARRY(REQ_USE_CARRY), .REQ_CARRY(REQ_CARRY),
    .MLU_A(MLU_A), .MLU_B(MLU_B), .MLU_OP(MLU_OP), .MLU_C_IN(MLU_C_IN),
    .MLU_OUT(MLU_OUT), .MLU_Z(MLU_Z), .MLU_C(MLU_C), .MLU_N(MLU_N),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_OUT(RES_OUT),
    .RES_Z(RES_Z), .RES_C(RES_C), .RES_N(RES_N), .DBG_STATE(DBG_STATE)
  );

  // clock / reset / watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Behavioural 32-bit MLU; C is deliberately junk (A[0]) for logic ops.
  always_comb begin
    MLU_OUT = 32'd0;
    MLU_C   = 1'b0;
    case (MLU_OP)
      OP_ADD: {MLU_C, MLU_OUT} = {1'b0, MLU_A} + {1'b0, MLU_B} + {32'd0, MLU_C_IN};
      OP_SUB: {MLU_C, MLU_OUT} = {1'b0, MLU_A} + {1'b0, ~MLU_B} + {32'd0, MLU_C_IN};
      OP_AND: begin MLU_OUT = MLU_A & MLU_B; MLU_C = MLU_A[0]; end
      OP_OR:  begin MLU_OUT = MLU_A | MLU_B; MLU_C = MLU_A[0]; end
      OP_XOR: begin MLU_OUT = MLU_A ^ MLU_B; MLU_C = MLU_A[0]; end
      OP_NOT: begin MLU_OUT = ~MLU_A;        MLU_C = MLU_A[0]; end
      default: begin MLU_OUT = 32'd0; MLU_C = 1'b0; end
    endcase
    MLU_Z = (MLU_OUT == 32'd0);
    MLU_N = MLU_OUT[31];
  end

  typedef struct packed {
    logic [63:0] out;
    logic        z;
    logic        c;
    logic        n;
  } res_t;

  // Reference: whole-width arithmetic, no notion of passes.
  function automatic res_t ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                     input logic wide, input logic uc, input logic cy);
    res_t r;
    logic cin;
    logic [64:0] s;
    logic [32:0] t;
    cin = uc ? cy : (op == OP_SUB);
    r = '0;
    if (wide) begin
      case (op)
        OP_ADD:  s = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        OP_SUB:  s = {1'b0, a} + {1'b0, ~b} + {64'd0, cin};
        OP_AND:  s = {1'b0, a & b};
        OP_OR:   s = {1'b0, a | b};
        OP_XOR:  s = {1'b0, a ^ b};
        OP_NOT:  s = {1'b0, ~a};
        default: s = 65'd0;
      endcase
      r.out = s[63:0];
      r.c   = (op == OP_ADD || op == OP_SUB) ? s[64] : 1'b0;
      r.n   = s[63];
    end else begin
      case (op)
        OP_ADD:  t = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'd0, cin};
        OP_SUB:  t = {1'b0, a[31:0]} + {1'b0, ~b[31:0]} + {32'd0, cin};
        OP_AND:  t = {1'b0, a[31:0] & b[31:0]};
        OP_OR:   t = {1'b0, a[31:0] | b[31:0]};
        OP_XOR:  t = {1'b0, a[31:0] ^ b[31:0]};
        OP_NOT:  t = {1'b0, ~a[31:0]};
        default: t = 33'd0;
      endcase
      r.out = {32'd0, t[31:0]};
      r.c   = (op == OP_ADD || op == OP_SUB) ? t[32] : 1'b0;
      r.n   = t[31];
    end
    r.z = (r.out == 64'd0);
    return r;
  endfunction

  // Driver: issues one request, waits for the result, holds RES_READY low for 'hold' cycles, then retires it.
  // lat counts cycles from the handshake cycle to the first cycle with RES_VALID (99 on timeout).
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic wide, input logic uc, input logic cy, input int hold,
                        output res_t got, output int lat, output logic [2:0] op1, output logic cin1,
                        output logic [2:0] op2, output logic cin2, output logic stable,
                        output logic post_valid, output logic post_ready);
    int cyc;
    res_t first;
    got = '0; op1 = '0; cin1 = 0; op2 = '0; cin2 = 0; stable = 1; post_valid = 1; post_ready = 0;
    lat = 99;
    @(negedge CLK);
    REQ_OP = op; REQ_A = a; REQ_B = b; REQ_WIDE = wide; REQ_USE_CARRY = uc; REQ_CARRY = cy;
    REQ_VALID = 1'b1;
    for (int w = 0; w < 10 && !REQ_READY; w++) @(negedge CLK);
    if (!REQ_READY) begin
      REQ_VALID = 1'b0;
      return;
    end
    cyc = 0;
    while (cyc < 10) begin
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      REQ_VALID = 1'b0;
      REQ_A = {$urandom, $urandom};
      if (cyc == 1) begin op1 = MLU_OP; cin1 = MLU_C_IN; end
      if (cyc == 2) begin op2 = MLU_OP; cin2 = MLU_C_IN; end
      if (RES_VALID) break;
    end
    if (!RES_VALID) return;
    lat = cyc;
    first = '{RES_OUT, RES_Z, RES_C, RES_N};
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (!RES_VALID || REQ_READY || (first !== res_t'({RES_OUT, RES_Z, RES_C, RES_N}))) stable = 0;
    end
    got = '{RES_OUT, RES_Z, RES_C, RES_N};
    RES_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RES_READY = 1'b0;
    post_valid = RES_VALID;
    post_ready = REQ_READY;
  endtask

  task automatic test_reset;
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    n_checks++; if (REQ_READY !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b expected 1", REQ_READY); end
    n_checks++; if (RES_VALID !== 1'b0) begin n_errors++; $display("FAIL reset_res_valid: got %b expected 0", RES_VALID); end
    n_checks++; if ({RES_OUT, RES_Z, RES_C, RES_N} !== 67'd0) begin n_errors++; $display("FAIL reset_res: got %h/%b%b%b expected 0", RES_OUT, RES_Z, RES_C, RES_N); end
    n_checks++; if ({MLU_OP, MLU_A, MLU_B, MLU_C_IN} !== {OP_NOP0, 65'd0}) begin n_errors++; $display("FAIL reset_mlu: got op %0d a %h b %h cin %b expected 0", MLU_OP, MLU_A, MLU_B, MLU_C_IN); end
  endtask

  task automatic test_wide_add;
    res_t g; int lat; logic [2:0] o1, o2; logic c1, c2, st, pv, pr;
    run_op(OP_ADD, 64'h0000_0000_FFFF_FFFF, 64'd1, 1, 0, 0, 0, g, lat, o1, c1, o2, c2, st, pv, pr);
    n_checks++; if (g.out !== 64'h0000_0001_0000_0000) begin n_errors++; $display("FAIL wide_add_out: got %h expected 0000000100000000", g.out); end
    n_checks++; if ({g.z, g.c, g.n} !== 3'b000) begin n_errors++; $display("FAIL wide_add_flags: got zcn=%b%b%b expected 000", g.z, g.c, g.n); end
    n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL wide_add_latency: got %0d expected 3", lat); end
    n_checks++; if (pv !== 1'b0 || pr !== 1'b1) begin n_errors++; $display("FAIL wide_add_retire: got valid %b ready %b expected 0 1", pv, pr); end
  endtask

  task automatic test_wide_sub;
    res_t g; int lat; logic [2:0] o1, o2; logic c1, c2, st, pv, pr;
    run_op(OP_SUB, 64'h0000_0001_0000_0000, 64'd1, 1, 0, 0, 0, g, lat, o1, c1, o2, c2, st, pv, pr);
    n_checks++; if (c1 !== 1'b1 || c2 !== 1'b0) begin n_errors++; $display("FAIL wide_sub_cin: got lo %b hi %b expected 1 0", c1, c2); end
    n_checks++; if (g.out !== 64'h0000_0000_FFFF_FFFF) begin n_errors++; $display("FAIL wide_sub_out: got %h expected 00000000ffffffff", g.out); end
    n_checks++; if ({g.z, g.c, g.n} !== 3'b010) begin n_errors++; $display("FAIL wide_sub_flags: got zcn=%b%b%b expected 010", g.z, g.c, g.n); end
  endtask

  task automatic test_narrow_xor;
    res_t g; int lat; logic [2:0] o1, o2; logic c1, c2, st, pv, pr;
    run_op(OP_XOR, 64'hDEAD_BEEF_1234_5678, 64'h0BAD_F00D_1234_5678, 0, 0, 0, 0, g, lat, o1, c1, o2, c2, st, pv, pr);
    n_checks++; if (g.out !== 64'd0 || g.z !== 1'b1 || g.c !== 1'b0) begin n_errors++; $display("FAIL narrow_xor_res: got %h z %b c %b expected 0 1 0", g.out, g.z, g.c); end
    n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL narrow_xor_latency: got %0d expected 2", lat); end
    n_checks++; if (o1 !== OP_XOR || o2 !== OP_NOP0) begin n_errors++; $display("FAIL narrow_xor_mlu_op: got lo %0d after %0d expected %0d 0", o1, o2, OP_XOR); end
  endtask

  task automatic test_backpressure;
    res_t g; int lat; logic [2:0] o1, o2; logic c1, c2, st, pv, pr;
    run_op(OP_ADD, 64'h0000_0000_7FFF_FFFF, 64'd1, 0, 0, 0, 5, g, lat, o1, c1, o2, c2, st, pv, pr);
    n_checks++; if (g.out !== 64'h0000_0000_8000_0000 || g.n !== 1'b1 || g.z !== 1'b0 || g.c !== 1'b0) begin n_errors++; $display("FAIL backpressure_res: got %h zcn=%b%b%b expected 80000000 001", g.out, g.z, g.c, g.n); end
    n_checks++; if (st !== 1'b1) begin n_errors++; $display("FAIL backpressure_stable: got %b expected 1", st); end
    n_checks++; if (pv !== 1'b0 || pr !== 1'b1) begin n_errors++; $display("FAIL backpressure_retire: got valid %b ready %b expected 0 1", pv, pr); end
  endtask

  task automatic test_reset_mid;
    res_t g, e; int lat; logic [2:0] o1, o2; logic c1, c2, st, pv, pr;
    logic [63:0] a, b;
    @(negedge CLK);
    REQ_OP = OP_ADD; REQ_A = 64'h1111_2222_3333_4444; REQ_B = 64'h5555_6666_7777_8888;
    REQ_WIDE = 1; REQ_USE_CARRY = 0; REQ_CARRY = 0; REQ_VALID = 1'b1;
    @(posedge CLK); @(negedge CLK);
    REQ_VALID = 1'b0;
    @(posedge CLK); @(negedge CLK);
    n_checks++; if (MLU_A !== 32'h1111_2222) begin n_errors++; $display("FAIL reset_mid_hi_pass: got mlu_a %h expected 11112222", MLU_A); end
    RST = 1'b1;
    @(posedge CLK); @(negedge CLK);
    RST = 1'b0;
    n_checks++; if (REQ_READY !== 1'b1 || RES_VALID !== 1'b0 || RES_OUT !== 64'd0) begin n_errors++; $display("FAIL reset_mid_state: got ready %b valid %b out %h expected 1 0 0", REQ_READY, RES_VALID, RES_OUT); end
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    e = ref_model(OP_ADD, a, b, 0, 0, 0);
    run_op(OP_ADD, a, b, 0, 0, 0, 0, g, lat, o1, c1, o2, c2, st, pv, pr);
    n_checks++; if (g !== e || lat !== 2) begin n_errors++; $display("FAIL reset_mid_next_op: got %h/%b%b%b lat %0d expected %h/%b%b%b lat 2", g.out, g.z, g.c, g.n, lat, e.out, e.z, e.c, e.n); end
  endtask

  task automatic test_random;
    res_t g, e; int lat; logic [2:0] o1, o2; logic c1, c2, st, pv, pr;
    logic [2:0] op; logic [63:0] a, b; logic wide, uc, cy;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      wide = 1'($urandom_range(0, 1)); uc = 1'($urandom_range(0, 1)); cy = 1'($urandom_range(0, 1));
      e = ref_model(op, a, b, wide, uc, cy);
      run_op(op, a, b, wide, uc, cy, $urandom_range(0, 2), g, lat, o1, c1, o2, c2, st, pv, pr);
      n_checks++; if (g !== e) begin n_errors++; $display("FAIL random_res[%0d] op %0d wide %b: got %h/%b%b%b expected %h/%b%b%b", i, op, wide, g.out, g.z, g.c, g.n, e.out, e.z, e.c, e.n); end
      n_checks++; if (lat !== (wide ? 3 : 2) || st !== 1'b1 || pv !== 1'b0) begin n_errors++; $display("FAIL random_timing[%0d]: got lat %0d stable %b post_valid %b expected %0d 1 0", i, lat, st, pv, wide ? 3 : 2); end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_q[$];
    logic [63:0] out_seen[2];
    int cyc_seen[2];
    int nres, sent, gap;
    logic acc;
    logic [63:0] a1, b1;
`ifdef MLU_SEQ_BACK_TO_BACK_EN
    gap = 2;
`else
    gap = 3;
`endif
    a1 = {32'd0, $urandom}; b1 = {32'd0, $urandom};
    exp_q.push_back(ref_model(OP_ADD, 64'd5, 64'd7, 0, 0, 0).out);
    exp_q.push_back(ref_model(OP_ADD, a1, b1, 0, 0, 0).out);
    nres = 0; sent = 0;
    @(negedge CLK);
    REQ_OP = OP_ADD; REQ_A = 64'd5; REQ_B = 64'd7; REQ_WIDE = 0; REQ_USE_CARRY = 0; REQ_CARRY = 0;
    REQ_VALID = 1'b1; RES_READY = 1'b1;
    for (int cyc = 0; cyc < 12 && nres < 2; cyc++) begin
      acc = REQ_VALID && REQ_READY;
      if (RES_VALID) begin cyc_seen[nres] = cyc; out_seen[nres] = RES_OUT; nres++; end
      @(posedge CLK); @(negedge CLK);
      if (acc) begin
        sent++;
        if (sent == 1) begin REQ_A = a1; REQ_B = b1; end
        else REQ_VALID = 1'b0;
      end
    end
    REQ_VALID = 1'b0; RES_READY = 1'b0;
    n_checks++; if (nres !== 2) begin n_errors++; $display("FAIL b2b_count: got %0d results expected 2", nres); end
    if (nres == 2) begin
      n_checks++; if (out_seen[0] !== exp_q[0] || out_seen[1] !== exp_q[1]) begin n_errors++; $display("FAIL b2b_res: got %h %h expected %h %h", out_seen[0], out_seen[1], exp_q[0], exp_q[1]); end
      n_checks++; if (cyc_seen[1] - cyc_seen[0] !== gap) begin n_errors++; $display("FAIL b2b_gap: got %0d expected %0d", cyc_seen[1] - cyc_seen[0], gap); end
    end
  endtask

  initial begin
    RST = 1'b1; REQ_VALID = 1'b0; REQ_OP = OP_NOP0; REQ_A = '0; REQ_B = '0;
    REQ_WIDE = 0; REQ_USE_CARRY = 0; REQ_CARRY = 0; RES_READY = 1'b0;
    test_reset;
    test_wide_add;
    test_wide_sub;
    test_narrow_xor;
    test_backpressure;
    test_reset_mid;
    test_random;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
